// File: rtl/data_mem_ls.sv
// data_mem_ls: RISC-V data memory with byte/half/word load-store formatting.
// Requests are taken on a valid/ready handshake and answered one cycle later
// with an extended load value or a fault flag. After reset the array can be
// swept to zero, one word per cycle, before requests are accepted.
module data_mem_ls #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH_WORDS    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  busy
);

    localparam int IDX = $clog2(DEPTH_WORDS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // One past the last legal byte address, one bit wider so it cannot wrap.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    logic [31:0]    mem [DEPTH_WORDS];
    logic [0:0]     state;
    logic [IDX-1:0] ptr;

    logic           accept;
    logic [IDX-1:0] idx;
    logic           legal;
    logic           misaligned;
    logic           out_of_range;
    logic           fault;
    logic [31:0]    word_rd;
    logic [31:0]    shifted;
    logic [31:0]    load_data;

    logic           wr_en;
    logic [IDX-1:0] wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;

    logic           resp_valid_q;
    logic [31:0]    resp_rdata_q;
    logic           resp_fault_q;

    assign req_ready  = !reset && (state == ST_IDLE);
    assign busy       = reset ? CLEAR_ON_RESET : (state == ST_CLEAR);
    assign accept     = req_valid && req_ready;
    assign idx        = req_addr[IDX+1:2];

    assign resp_valid = resp_valid_q && !reset;
    assign resp_rdata = reset ? 32'h0 : resp_rdata_q;
    assign resp_fault = resp_fault_q && !reset;

    // Decide whether the request is a legal, aligned, in-range access.
    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end

        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase

        out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
        fault        = !legal || misaligned || out_of_range;
    end

    // Pull the addressed byte/half down to bit 0 and extend it.
    always_comb begin
        word_rd = mem[idx];
        shifted = word_rd >> {req_addr[1:0], 3'b000};
        case (req_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    // Single write port shared by the clear sweep and byte-masked stores.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = 4'h0;
        wr_data = 32'h0;
        if (!reset && (state == ST_CLEAR)) begin
            wr_en   = 1'b1;
            wr_idx  = ptr;
            wr_be   = 4'hF;
            wr_data = 32'h0;
        end else if (accept && req_we && !fault) begin
            wr_en = 1'b1;
            case (req_funct3[1:0])
                2'b00: begin
                    wr_be   = 4'b0001 << req_addr[1:0];
                    wr_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    wr_be   = 4'hF;
                    wr_data = req_wdata;
                end
            endcase
        end
    end

    // Commit enabled byte lanes of the selected word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Sweep controller: walk the clear pointer once, then sit in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            ptr   <= '0;
        end else if (state == ST_CLEAR) begin
            ptr <= ptr + IDX'(1);
            if (ptr == IDX'(DEPTH_WORDS - 1)) begin
                state <= ST_IDLE;
            end
        end
    end

    // Register the response; stores and faults always return zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            resp_fault_q <= accept && fault;
            resp_rdata_q <= (accept && !req_we && !fault) ? load_data : 32'h0;
        end
    end

endmodule
